// File: rtl/lcd_key_pio_in_if.sv
// Avalon-MM slave bus bundle for lcd_key_pio_in.
// The master drives the strobes and write data; the slave returns registered read data.
interface lcd_key_pio_in_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [1:0]       address;
    logic             chipselect;
    logic             read_n;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lcd_key_pio_in.sv
// Key input PIO: 2-flop sync, optional per-bit debounce (LCD_KEY_DEBOUNCE_EN),
// falling-edge capture with W1C clear, masked level irq.
module lcd_key_pio_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    lcd_key_pio_in_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IdleLevel = {WIDTH{RESET_LEVEL}};

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic             rd_en, wr_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= IdleLevel;
            sync_q <= IdleLevel;
        end else begin
            meta_q <= in_port;
            sync_q <= meta_q;
        end
    end

`ifdef LCD_KEY_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;

    // The counter only runs while sync disagrees with data, so it tops out at CntMax.
    always_comb begin
        data_d = data_q;
        cnt_d  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync_q[i] != data_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    data_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        data_d = sync_q;
    end
`endif

    assign rd_en = bus.chipselect & ~bus.read_n;
    assign wr_en = bus.chipselect & ~bus.write_n;

    always_comb begin
        mask_d    = mask_q;
        edgecap_d = edgecap_q;
        if (wr_en && bus.address == 2'd2) begin
            mask_d = bus.writedata;
        end
        if (wr_en && bus.address == 2'd3) begin
            edgecap_d = edgecap_q & ~bus.writedata;
        end
        // Press events are OR-ed in last so they win over a same-cycle clear.
        edgecap_d = edgecap_d | (data_q & ~data_d);
    end

    // Reads sample pre-edge state, so a same-cycle write or capture is not visible.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (bus.address)
                2'd0:    readdata_d = data_q;
                2'd1:    readdata_d = '0;
                2'd2:    readdata_d = mask_q;
                default: readdata_d = edgecap_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q     <= IdleLevel;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edgecap_q & mask_q);

endmodule
